// File: rtl/sv39_pkg.sv
// Shared Sv39 definitions: PTE bit positions, walk levels, FSM states,
// the TLB entry layout, and PA / permission helpers.
package sv39_pkg;
  localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  typedef enum logic [1:0] {LVL0 = 2'd0, LVL1 = 2'd1, LVL2 = 2'd2} lvl_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_L2 = 3'd1, S_L1 = 3'd2, S_L0 = 3'd3, S_RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] asid;
    logic [26:0] vpn;
    logic [43:0] ppn;
    lvl_e        level;
    logic        r;
    logic        w;
    logic        x;
    logic        u;
    logic        g;
    logic        a;
    logic        d;
  } tlb_entry_t;

  localparam int ENT_W = $bits(tlb_entry_t);

  // Superpages pass the low VPN fields of the VA straight through into the PPN.
  function automatic logic [63:0] make_pa(input logic [43:0] ppn, input lvl_e lvl,
                                          input logic [38:0] va);
    logic [43:0] p;
    p = ppn;
    if (lvl != LVL0) p[8:0]  = va[20:12];
    if (lvl == LVL2) p[17:9] = va[29:21];
    return {8'b0, p, va[11:0]};
  endfunction

  function automatic logic perm_ok(input logic r, input logic w, input logic x,
                                   input logic a, input logic d,
                                   input logic is_data, input logic is_store);
    return a & (is_data ? (is_store ? (w & d) : r) : x);
  endfunction
endpackage

// File: rtl/sv39_tlb_array.sv
// Fully-associative TLB: dual combinational lookup (fetch/data), one fill port
// written at the round-robin pointer, and a whole-array flush.
module sv39_tlb_array
  import sv39_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter bit ASID_EN     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fill_en,
  input  logic [ENT_W-1:0] fill_ent,
  input  logic [15:0]      asid,
  input  logic [26:0]      i_vpn,
  input  logic [26:0]      d_vpn,
  output logic             i_hit,
  output logic [ENT_W-1:0] i_ent,
  output logic             d_hit,
  output logic [ENT_W-1:0] d_ent
);
  localparam int IW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  tlb_entry_t [TLB_ENTRIES-1:0] ent_q, ent_d;
  logic [IW-1:0] rr_q, rr_d;
  tlb_entry_t fe, i_e, d_e;

  assign fe    = fill_ent;
  assign i_ent = i_e;
  assign d_ent = d_e;

  function automatic logic match(input tlb_entry_t e, input logic [26:0] vpn,
                                 input logic [15:0] a);
    logic m;
    m = e.valid && (e.vpn[26:18] == vpn[26:18]);
    if (e.level != LVL2) m = m && (e.vpn[17:9] == vpn[17:9]);
    if (e.level == LVL0) m = m && (e.vpn[8:0] == vpn[8:0]);
    if (ASID_EN) m = m && (e.asid == a);
    return m;
  endfunction

  always_comb begin
    i_hit = 1'b0;
    d_hit = 1'b0;
    i_e   = '0;
    d_e   = '0;
    for (int k = 0; k < TLB_ENTRIES; k++) begin
      if (!i_hit && match(ent_q[k], i_vpn, asid)) begin
        i_hit = 1'b1;
        i_e   = ent_q[k];
      end
      if (!d_hit && match(ent_q[k], d_vpn, asid)) begin
        d_hit = 1'b1;
        d_e   = ent_q[k];
      end
    end
  end

  // A flush in the same cycle as a fill wins: nothing is written.
  always_comb begin
    ent_d = ent_q;
    rr_d  = rr_q;
    if (fill_en && !flush) begin
      ent_d[rr_q] = fe;
      rr_d        = rr_q + IW'(1);
    end
    if (flush) begin
      for (int k = 0; k < TLB_ENTRIES; k++) ent_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
      rr_q  <= '0;
    end else begin
      ent_q <= ent_d;
      rr_q  <= rr_d;
    end
  end
endmodule

// File: rtl/sv39_xlate_tlb.sv
// Two-channel Sv39 translator: zero-latency TLB hits, a single shared page-table
// walker for misses (data has priority), faults, superpages, sfence, bypass.
module sv39_xlate_tlb
  import sv39_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int XLEN        = 64,
  parameter bit ASID_EN     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] satp,
  input  logic            priv_m,
  input  logic            sfence,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_va,
  output logic            i_ready,
  output logic [XLEN-1:0] i_pa,
  output logic            i_fault,
  input  logic            d_req,
  input  logic [XLEN-1:0] d_va,
  input  logic            d_store,
  output logic            d_ready,
  output logic [XLEN-1:0] d_pa,
  output logic            d_fault,
  output logic            ptw_req,
  output logic [XLEN-1:0] ptw_addr,
  input  logic            ptw_stall,
  input  logic [XLEN-1:0] ptw_rdata
);
  state_e      state_q, state_d;
  logic        chan_d_q, chan_d_d;
  logic        store_q, store_d;
  logic [38:0] va_q, va_d;
  logic [15:0] asid_q, asid_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] pte_q, pte_d;
  lvl_e        lvl_q, lvl_d;
  logic        fault_q, fault_d;
  logic        flushed_q, flushed_d;

  logic bypass, i_hit, d_hit, i_miss, d_miss, resp, ptw_done, fill_en, misalign;
  logic [ENT_W-1:0] i_ent_w, d_ent_w, fill_w;
  tlb_entry_t i_e, d_e, fill_e;
  lvl_e cur_lvl;
  logic [38:0] sel_va;
  logic [8:0] next_vpn;
  logic [63:0] walk_pa;

  assign bypass = (satp[63:60] != SATP_MODE_SV39) || priv_m;
  assign i_e    = i_ent_w;
  assign d_e    = d_ent_w;
  assign fill_w = fill_e;

  sv39_tlb_array #(.TLB_ENTRIES(TLB_ENTRIES), .ASID_EN(ASID_EN)) u_tlb (
    .clk(clk), .rst(rst), .flush(sfence), .fill_en(fill_en), .fill_ent(fill_w),
    .asid(satp[59:44]), .i_vpn(i_va[38:12]), .d_vpn(d_va[38:12]),
    .i_hit(i_hit), .i_ent(i_ent_w), .d_hit(d_hit), .d_ent(d_ent_w)
  );

  assign i_miss   = i_req && !bypass && !i_hit;
  assign d_miss   = d_req && !bypass && !d_hit;
  assign resp     = (state_q == S_RESP);
  assign ptw_req  = (state_q == S_L2) || (state_q == S_L1) || (state_q == S_L0);
  assign ptw_addr = XLEN'(addr_q);
  assign ptw_done = ptw_req && !ptw_stall;
  assign cur_lvl  = (state_q == S_L2) ? LVL2 : (state_q == S_L1) ? LVL1 : LVL0;
  assign sel_va   = d_miss ? d_va[38:0] : i_va[38:0];
  assign next_vpn = (state_q == S_L2) ? va_q[29:21] : va_q[20:12];
  assign misalign = ((cur_lvl == LVL2) && (ptw_rdata[27:10] != 18'd0)) ||
                    ((cur_lvl == LVL1) && (ptw_rdata[18:10] != 9'd0));
  assign walk_pa  = make_pa(pte_q[53:10], lvl_q, va_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      chan_d_q  <= 1'b0;
      store_q   <= 1'b0;
      va_q      <= '0;
      asid_q    <= '0;
      addr_q    <= '0;
      pte_q     <= '0;
      lvl_q     <= LVL0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_d_q  <= chan_d_d;
      store_q   <= store_d;
      va_q      <= va_d;
      asid_q    <= asid_d;
      addr_q    <= addr_d;
      pte_q     <= pte_d;
      lvl_q     <= lvl_d;
      fault_q   <= fault_d;
      flushed_q <= flushed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d_d  = chan_d_q;
    store_d   = store_q;
    va_d      = va_q;
    asid_d    = asid_q;
    addr_d    = addr_q;
    pte_d     = pte_q;
    lvl_d     = lvl_q;
    fault_d   = fault_q;
    flushed_d = flushed_q || sfence;
    case (state_q)
      S_IDLE: begin
        if (d_miss || i_miss) begin
          state_d   = S_L2;
          chan_d_d  = d_miss;
          store_d   = d_miss && d_store;
          va_d      = sel_va;
          asid_d    = satp[59:44];
          addr_d    = {8'b0, satp[43:0], sel_va[38:30], 3'b0};
          fault_d   = 1'b0;
          flushed_d = sfence;
        end
      end
      S_L2, S_L1, S_L0: begin
        if (ptw_done) begin
          if (!ptw_rdata[PTE_V] || (!ptw_rdata[PTE_R] && ptw_rdata[PTE_W])) begin
            fault_d = 1'b1;
            state_d = S_RESP;
          end else if (ptw_rdata[PTE_R] || ptw_rdata[PTE_X]) begin
            pte_d   = 64'(ptw_rdata);
            lvl_d   = cur_lvl;
            fault_d = misalign || !perm_ok(ptw_rdata[PTE_R], ptw_rdata[PTE_W],
                        ptw_rdata[PTE_X], ptw_rdata[PTE_A], ptw_rdata[PTE_D],
                        chan_d_q, store_q);
            state_d = S_RESP;
          end else if (state_q == S_L0) begin
            fault_d = 1'b1;
            state_d = S_RESP;
          end else begin
            addr_d  = {8'b0, ptw_rdata[53:10], next_vpn, 3'b0};
            state_d = (state_q == S_L2) ? S_L1 : S_L0;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fill_en      = resp && !fault_q && !flushed_q;
    fill_e       = '0;
    fill_e.valid = 1'b1;
    fill_e.asid  = asid_q;
    fill_e.vpn   = va_q[38:12];
    fill_e.ppn   = pte_q[53:10];
    fill_e.level = lvl_q;
    fill_e.r     = pte_q[PTE_R];
    fill_e.w     = pte_q[PTE_W];
    fill_e.x     = pte_q[PTE_X];
    fill_e.u     = pte_q[PTE_U];
    fill_e.g     = pte_q[PTE_G];
    fill_e.a     = pte_q[PTE_A];
    fill_e.d     = pte_q[PTE_D];

    i_ready = 1'b0;
    i_pa    = '0;
    i_fault = 1'b0;
    if (!rst && i_req) begin
      if (bypass) begin
        i_ready = 1'b1;
        i_pa    = i_va;
      end else if (resp && !chan_d_q) begin
        i_ready = 1'b1;
        i_pa    = XLEN'(walk_pa);
        i_fault = fault_q;
      end else if (i_hit) begin
        i_ready = 1'b1;
        i_pa    = XLEN'(make_pa(i_e.ppn, i_e.level, i_va[38:0]));
        i_fault = !perm_ok(i_e.r, i_e.w, i_e.x, i_e.a, i_e.d, 1'b0, 1'b0);
      end
    end

    d_ready = 1'b0;
    d_pa    = '0;
    d_fault = 1'b0;
    if (!rst && d_req) begin
      if (bypass) begin
        d_ready = 1'b1;
        d_pa    = d_va;
      end else if (resp && chan_d_q) begin
        d_ready = 1'b1;
        d_pa    = XLEN'(walk_pa);
        d_fault = fault_q;
      end else if (d_hit) begin
        d_ready = 1'b1;
        d_pa    = XLEN'(make_pa(d_e.ppn, d_e.level, d_va[38:0]));
        d_fault = !perm_ok(d_e.r, d_e.w, d_e.x, d_e.a, d_e.d, 1'b1, d_store);
      end
    end
  end
endmodule

// File: tb/tb_sv39_xlate_tlb.sv
// Directed bench for sv39_xlate_tlb with a small PTE memory model.
module tb_sv39_xlate_tlb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] satp = '0;
  logic        priv_m = 1'b0, sfence = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_store = 1'b0;
  logic [63:0] i_va = '0, d_va = '0;
  logic        i_ready, i_fault, d_ready, d_fault, ptw_req;
  logic [63:0] i_pa, d_pa, ptw_addr;
  logic        ptw_stall = 1'b0;
  logic [63:0] ptw_rdata = '0;

  int n_chk = 0, n_fail = 0;
  logic [63:0] mem_a [8];
  logic [63:0] mem_d [8];
  logic [63:0] rd_q [$];

  localparam logic [63:0] SV39 = 64'h8000000000080000;

  sv39_xlate_tlb #(.TLB_ENTRIES(8), .XLEN(64), .ASID_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .satp(satp), .priv_m(priv_m), .sfence(sfence),
    .i_req(i_req), .i_va(i_va), .i_ready(i_ready), .i_pa(i_pa), .i_fault(i_fault),
    .d_req(d_req), .d_va(d_va), .d_store(d_store), .d_ready(d_ready), .d_pa(d_pa),
    .d_fault(d_fault), .ptw_req(ptw_req), .ptw_addr(ptw_addr), .ptw_stall(ptw_stall),
    .ptw_rdata(ptw_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (mem_a[k] == a) r = mem_d[k];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    ptw_rdata = mem_rd(ptw_addr);
  end

  always @(negedge clk) if (!rst && ptw_req && !ptw_stall) rd_q.push_back(ptw_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mem_clear();
    for (int k = 0; k < 8; k++) begin
      mem_a[k] = 64'hFFFF_FFFF_FFFF_FFF8;
      mem_d[k] = '0;
    end
  endtask

  task automatic pulse_sfence();
    @(negedge clk); sfence = 1'b1;
    @(negedge clk); sfence = 1'b0;
  endtask

  task automatic do_d(input logic [63:0] va, input logic st, output logic [63:0] pa,
                      output logic flt, output int cyc);
    logic got;
    @(negedge clk);
    d_va = va; d_store = st; d_req = 1'b1;
    cyc = 0; got = 1'b0; pa = '0; flt = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1; cyc++;
      if (d_ready) begin got = 1'b1; pa = d_pa; flt = d_fault; end
      else @(negedge clk);
    end
    if (!got) chk("d_timeout", 64'(got), 64'd1);
    @(negedge clk); d_req = 1'b0; d_store = 1'b0;
  endtask

  task automatic do_i(input logic [63:0] va, output logic [63:0] pa,
                      output logic flt, output int cyc);
    logic got;
    @(negedge clk);
    i_va = va; i_req = 1'b1;
    cyc = 0; got = 1'b0; pa = '0; flt = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      #1; cyc++;
      if (i_ready) begin got = 1'b1; pa = i_pa; flt = i_fault; end
      else @(negedge clk);
    end
    if (!got) chk("i_timeout", 64'(got), 64'd1);
    @(negedge clk); i_req = 1'b0;
  endtask

  task automatic set_tree(input logic [63:0] leaf);
    mem_clear();
    mem_a[0] = 64'h80000010; mem_d[0] = 64'h20000401;
    mem_a[1] = 64'h80001008; mem_d[1] = 64'h20000801;
    mem_a[2] = 64'h80002000; mem_d[2] = leaf;
  endtask

  logic [63:0] pa, pa2;
  logic flt, flt2;
  int cyc, cyc2;

  initial begin
    mem_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_i_ready", 64'(i_ready), 0);
    chk("rst_d_ready", 64'(d_ready), 0);
    chk("rst_ptw_req", 64'(ptw_req), 0);
    chk("rst_ptw_addr", ptw_addr, 0);
    chk("rst_faults", {62'd0, i_fault, d_fault}, 0);

    // Bare mode and M-mode bypass
    rd_q.delete();
    do_i(64'h80000004, pa, flt, cyc);
    chk("byp_i_pa", pa, 64'h80000004);
    chk("byp_i_cyc", 64'(cyc), 1);
    satp = SV39; priv_m = 1'b1;
    do_d(64'h1234, 1'b0, pa, flt, cyc);
    chk("byp_m_pa", pa, 64'h1234);
    chk("byp_m_cyc", 64'(cyc), 1);
    chk("byp_reads", 64'(rd_q.size()), 0);
    priv_m = 1'b0;

    // Three-level walk then zero-latency hit
    set_tree(64'h201000CF);
    rd_q.delete();
    do_d(64'h80200ABC, 1'b0, pa, flt, cyc);
    chk("walk_pa", pa, 64'h80400ABC);
    chk("walk_fault", 64'(flt), 0);
    chk("walk_cyc", 64'(cyc), 5);
    chk("walk_nrd", 64'(rd_q.size()), 3);
    if (rd_q.size() == 3) begin
      chk("walk_rd0", rd_q[0], 64'h80000010);
      chk("walk_rd1", rd_q[1], 64'h80001008);
      chk("walk_rd2", rd_q[2], 64'h80002000);
    end
    rd_q.delete();
    do_d(64'h80200ABC, 1'b0, pa, flt, cyc);
    chk("hit_pa", pa, 64'h80400ABC);
    chk("hit_cyc", 64'(cyc), 1);
    do_i(64'h80200ABC, pa, flt, cyc);
    chk("hit_i_pa", pa, 64'h80400ABC);
    chk("hit_i_cyc", 64'(cyc), 1);
    chk("hit_nrd", 64'(rd_q.size()), 0);

    // Gigapage leaf at the root, then a hit elsewhere in the same gigapage
    pulse_sfence();
    mem_clear();
    mem_a[0] = 64'h80000010; mem_d[0] = 64'h200000CF;
    rd_q.delete();
    do_i(64'h80200ABC, pa, flt, cyc);
    chk("giga_pa", pa, 64'h80200ABC);
    chk("giga_fault", 64'(flt), 0);
    chk("giga_cyc", 64'(cyc), 3);
    chk("giga_nrd", 64'(rd_q.size()), 1);
    do_d(64'h80312345, 1'b0, pa, flt, cyc);
    chk("giga_hit_pa", pa, 64'h80312345);
    chk("giga_hit_cyc", 64'(cyc), 1);
    pulse_sfence();
    mem_d[0] = 64'h200004CF;
    rd_q.delete();
    do_i(64'h80200ABC, pa, flt, cyc);
    chk("giga_misalign", 64'(flt), 1);
    chk("giga_mis_nrd", 64'(rd_q.size()), 1);

    // Store to a leaf without W/D: faults, never filled
    pulse_sfence();
    set_tree(64'h2010004B);
    rd_q.delete();
    do_d(64'h80200ABC, 1'b1, pa, flt, cyc);
    chk("st_fault", 64'(flt), 1);
    do_d(64'h80200ABC, 1'b1, pa, flt, cyc);
    chk("st_refault", 64'(flt), 1);
    chk("st_rewalk_nrd", 64'(rd_q.size()), 6);
    do_d(64'h80200ABC, 1'b0, pa, flt, cyc);
    chk("ld_ok_pa", pa, 64'h80400ABC);
    chk("ld_ok_fault", 64'(flt), 0);
    do_d(64'h80200ABC, 1'b1, pa, flt, cyc);
    chk("st_hit_fault", 64'(flt), 1);
    chk("st_hit_cyc", 64'(cyc), 1);

    // Invalid root PTE
    pulse_sfence();
    mem_clear();
    rd_q.delete();
    do_d(64'h80200ABC, 1'b0, pa, flt, cyc);
    chk("v0_fault", 64'(flt), 1);
    chk("v0_nrd", 64'(rd_q.size()), 1);
    chk("v0_cyc", 64'(cyc), 3);

    // Simultaneous misses: data walk first, fetch afterwards
    pulse_sfence();
    set_tree(64'h201000CF);
    mem_a[3] = 64'h80000008; mem_d[3] = 64'h300000CF;
    rd_q.delete();
    fork
      do_d(64'h80200ABC, 1'b0, pa, flt, cyc);
      do_i(64'h40000123, pa2, flt2, cyc2);
    join
    chk("arb_d_pa", pa, 64'h80400ABC);
    chk("arb_d_cyc", 64'(cyc), 5);
    chk("arb_i_pa", pa2, 64'hC0000123);
    chk("arb_i_cyc", 64'(cyc2), 8);
    chk("arb_nrd", 64'(rd_q.size()), 4);
    if (rd_q.size() == 4) begin
      chk("arb_rd0", rd_q[0], 64'h80000010);
      chk("arb_rd3", rd_q[3], 64'h80000008);
    end

    // sfence during a fetch walk: response delivered, no fill
    pulse_sfence();
    rd_q.delete();
    fork
      do_i(64'h80200ABC, pa, flt, cyc);
      begin
        repeat (2) @(negedge clk);
        sfence = 1'b1;
        @(negedge clk);
        sfence = 1'b0;
      end
    join
    chk("sf_pa", pa, 64'h80400ABC);
    chk("sf_cyc", 64'(cyc), 5);
    do_i(64'h80200ABC, pa, flt, cyc);
    chk("sf_remiss_cyc", 64'(cyc), 5);
    chk("sf_nrd", 64'(rd_q.size()), 6);

    // Reset in the middle of a stalled walk
    pulse_sfence();
    ptw_stall = 1'b1;
    @(negedge clk);
    d_va = 64'h80200ABC; d_req = 1'b1;
    @(negedge clk); #1;
    chk("rstw_req", 64'(ptw_req), 1);
    chk("rstw_addr", ptw_addr, 64'h80000010);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstw_req_drop", 64'(ptw_req), 0);
    chk("rstw_addr_clr", ptw_addr, 0);
    chk("rstw_d_ready", 64'(d_ready), 0);
    d_req = 1'b0; ptw_stall = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=done", n_chk);
    $fatal(1, "timeout");
  end
endmodule
